// File: rtl/pwm_ramp_ctrl.sv
// Bus-mapped duty sequencer for NumChannels PWM channels; duties change only at period wraps.
// Define PWM_RAMP_CTRL_RAMP_EN for rate-limited ramping; otherwise duties jump to target at each wrap.
module pwm_ramp_ctrl #(
   parameter int unsigned NumChannels = 4,
   parameter int unsigned CtrSize     = 8,
   parameter int unsigned RateSize    = 8
) (
   input  logic                           clk_sys_i,
   input  logic                           rst_sys_ni,
   input  logic                           device_req_i,
   input  logic [31:0]                    device_addr_i,
   input  logic                           device_we_i,
   input  logic [3:0]                     device_be_i,
   input  logic [31:0]                    device_wdata_i,
   output logic                           device_rvalid_o,
   output logic [31:0]                    device_rdata_o,
   output logic [NumChannels*CtrSize-1:0] pulse_width_o,
   output logic                           period_wrap_o
);

   logic [CtrSize-1:0]     ctr;
   logic                   wrap;
   logic                   en;
   logic [CtrSize-1:0]     target   [NumChannels];
   logic [CtrSize-1:0]     active_q [NumChannels];
   logic [CtrSize-1:0]     active_d [NumChannels];
   logic [NumChannels-1:0] busy;
   logic [5:0]             widx;
   logic                   wr_en;
   logic [31:0]            rd_val;
   logic                   unused_addr;

   assign widx          = device_addr_i[7:2];
   assign unused_addr   = ^{device_addr_i[31:8], device_addr_i[1:0]};
   assign wr_en         = device_req_i & device_we_i;
   assign wrap          = &ctr;
   assign period_wrap_o = wrap;

   function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [3:0] be);
      logic [31:0] mask;
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      return (old & ~mask) | (wd & mask);
   endfunction

`ifdef PWM_RAMP_CTRL_RAMP_EN
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STEP} ramp_state_e;
   ramp_state_e         state_q [NumChannels];
   ramp_state_e         state_d [NumChannels];
   logic [RateSize-1:0] rate    [NumChannels];
   logic [RateSize-1:0] presc_q [NumChannels];
   logic [RateSize-1:0] presc_d [NumChannels];
`else
   logic [RateSize-1:0] unused_rate;
   assign unused_rate = '0;
`endif

   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) ctr <= '0;
      else             ctr <= ctr + CtrSize'(1);
   end

   always_comb begin
      busy = '0;
      for (int i = 0; i < NumChannels; i++) busy[i] = (active_q[i] != target[i]);
   end

   always_comb begin
      rd_val = '0;
      if (widx == 6'd0)      rd_val = {31'd0, en};
      else if (widx == 6'd1) rd_val = 32'(busy);
      for (int i = 0; i < NumChannels; i++) begin
         if (widx == 6'(4 + 2*i)) rd_val = 32'(target[i]);
`ifdef PWM_RAMP_CTRL_RAMP_EN
         if (widx == 6'(5 + 2*i)) rd_val = 32'(rate[i]);
`endif
      end
   end

   // Read data is captured from pre-edge register values, so a same-cycle write never leaks in.
   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         en              <= 1'b0;
         device_rvalid_o <= 1'b0;
         device_rdata_o  <= '0;
         for (int i = 0; i < NumChannels; i++) begin
            target[i] <= '0;
`ifdef PWM_RAMP_CTRL_RAMP_EN
            rate[i]   <= '0;
`endif
         end
      end else begin
         device_rvalid_o <= device_req_i;
         device_rdata_o  <= (device_req_i && !device_we_i) ? rd_val : '0;
         if (wr_en) begin
            if (widx == 6'd0 && device_be_i[0]) en <= device_wdata_i[0];
            for (int i = 0; i < NumChannels; i++) begin
               if (widx == 6'(4 + 2*i))
                  target[i] <= CtrSize'(merge_be(32'(target[i]), device_wdata_i, device_be_i));
`ifdef PWM_RAMP_CTRL_RAMP_EN
               if (widx == 6'(5 + 2*i))
                  rate[i] <= RateSize'(merge_be(32'(rate[i]), device_wdata_i, device_be_i));
`endif
            end
         end
      end
   end

`ifdef PWM_RAMP_CTRL_RAMP_EN
   always_comb begin
      for (int i = 0; i < NumChannels; i++) begin
         active_d[i] = active_q[i];
         state_d[i]  = state_q[i];
         presc_d[i]  = presc_q[i];
         if (!en) begin
            active_d[i] = '0;
            state_d[i]  = S_IDLE;
         end else if (wrap) begin
            case (state_q[i])
               S_IDLE: if (busy[i]) begin
                  presc_d[i] = rate[i];
                  state_d[i] = S_WAIT;
               end
               S_WAIT: if (presc_q[i] == '0) state_d[i] = S_STEP;
                       else                  presc_d[i] = presc_q[i] - RateSize'(1);
               default: state_d[i] = S_IDLE;
            endcase
            // STEP acts in the same wrap it is reached: RATE=0 yields one step per period.
            if (state_d[i] == S_STEP) begin
               if (active_q[i] < target[i])      active_d[i] = active_q[i] + CtrSize'(1);
               else if (active_q[i] > target[i]) active_d[i] = active_q[i] - CtrSize'(1);
               if (active_d[i] == target[i]) begin
                  state_d[i] = S_IDLE;
               end else begin
                  state_d[i] = S_WAIT;
                  presc_d[i] = rate[i];
               end
            end
         end
      end
   end

   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         for (int i = 0; i < NumChannels; i++) begin
            active_q[i] <= '0;
            state_q[i]  <= S_IDLE;
            presc_q[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NumChannels; i++) begin
            active_q[i] <= active_d[i];
            state_q[i]  <= state_d[i];
            presc_q[i]  <= presc_d[i];
         end
      end
   end
`else
   always_comb begin
      for (int i = 0; i < NumChannels; i++) begin
         active_d[i] = active_q[i];
         if (!en)       active_d[i] = '0;
         else if (wrap) active_d[i] = target[i];
      end
   end

   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         for (int i = 0; i < NumChannels; i++) active_q[i] <= '0;
      end else begin
         for (int i = 0; i < NumChannels; i++) active_q[i] <= active_d[i];
      end
   end
`endif

   // Gating with en makes the output drop the cycle right after EN is cleared.
   always_comb begin
      pulse_width_o = '0;
      for (int i = 0; i < NumChannels; i++)
         pulse_width_o[i*CtrSize +: CtrSize] = en ? active_q[i] : '0;
   end

endmodule
